// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Adds or subtracts two NWORDS x 16-bit operands one word per accept,
//   least-significant word first. The carry ripples between words in a
//   register. Each result word is delivered through a one-entry output
//   register with valid/ready.
//
// Parameters
//   NWORDS        words per operand (2..16)
//
// Ports
//   clk, rst_n            clock; async active-low reset
//   start, sub            begin op (IDLE only); sub=1 selects A-B
//   in_valid/in_ready     operand-word handshake; a_word, b_word operands
//   out_valid/out_ready   result-word handshake; sum_word result, last final
//   carry_out             final carry (add) / not-borrow (sub), held
//   busy                  not in IDLE
//   overflow              signed overflow of the op, held
//                         (only with MULTIWORD_SIGNED_OVF_EN)
//
// Build option: `define MULTIWORD_SIGNED_OVF_EN adds the overflow output.
module multiword_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_word,
  input  logic [15:0] b_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum_word,
  output logic        last,
  output logic        carry_out,
`ifdef MULTIWORD_SIGNED_OVF_EN
  output logic        overflow,
`endif
  output logic        busy
);

  localparam int CW = $clog2(NWORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic          r_sub;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic [15:0]   r_sum;
  logic          r_last;
  logic          r_carry_out;

  logic [15:0]   w_b_eff;
  logic [16:0]   w_sum;
  logic          w_accept;
  logic          w_take;
  logic          w_final;

  // Subtract as A + ~B + 1: the +1 comes from the carry register,
  // which is preloaded with sub at start.
  assign w_b_eff  = r_sub ? ~b_word : b_word;
  assign w_sum    = {1'b0, a_word} + {1'b0, w_b_eff} + {16'd0, r_carry};
  assign w_accept = in_valid && in_ready;
  assign w_take   = r_out_valid && out_ready;
  assign w_final  = w_accept && (r_cnt == LAST_IDX);

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)            w_next = S_RUN;
      S_RUN:   if (w_final)          w_next = S_DRAIN;
      S_DRAIN: if (w_take && r_last) w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // The output register may be refilled in the same cycle it drains,
  // hence the out_ready term in in_ready.
  always_comb begin
    busy     = (r_state != S_IDLE);
    in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= 16'h0000;
      r_last      <= 1'b0;
      r_carry_out <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_sub   <= sub;
        r_carry <= sub;
        r_cnt   <= '0;
      end
      if (w_accept) begin
        r_sum       <= w_sum[15:0];
        r_carry     <= w_sum[16];
        r_cnt       <= r_cnt + CW'(1);
        r_last      <= (r_cnt == LAST_IDX);
        r_out_valid <= 1'b1;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
        r_last      <= 1'b0;
      end
      // The last word is only ever produced by the final accept, so
      // r_carry already holds the final carry at this handshake.
      if (w_take && r_last) r_carry_out <= r_carry;
    end
  end

`ifdef MULTIWORD_SIGNED_OVF_EN
  logic w_ovf;
  logic r_ovf_pend;
  logic r_ovf;
  // Carry into bit 15 is recovered from the sum bit; XOR with carry out.
  assign w_ovf = a_word[15] ^ w_b_eff[15] ^ w_sum[15] ^ w_sum[16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_final)          r_ovf_pend <= w_ovf;
      if (w_take && r_last) r_ovf      <= r_ovf_pend;
    end
  end
  assign overflow = r_ovf;
`endif

  assign out_valid = r_out_valid;
  assign sum_word  = r_sum;
  assign last      = r_last;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int N = 4;
  localparam int W = 16 * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a_word = '0, b_word = '0;
  logic        in_ready, out_valid, last, carry_out, busy;
  logic [15:0] sum_word;
`ifdef MULTIWORD_SIGNED_OVF_EN
  logic        overflow;
`endif

  multiword_add_sequencer #(.NWORDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_word(a_word), .b_word(b_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_word(sum_word), .last(last), .carry_out(carry_out),
`ifdef MULTIWORD_SIGNED_OVF_EN
    .overflow(overflow),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: whole-operand arithmetic, then split into words.
  logic [W-1:0] ref_r;
  logic         ref_c, ref_v;
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    if (!s) begin
      t     = {1'b0, a} + {1'b0, b};
      ref_r = t[W-1:0];
      ref_c = t[W];
      ref_v = (a[W-1] == b[W-1]) && (ref_r[W-1] != a[W-1]);
    end else begin
      ref_r = a - b;
      ref_c = (a >= b);
      ref_v = (a[W-1] != b[W-1]) && (ref_r[W-1] != a[W-1]);
    end
  endtask

  task automatic do_start(input logic s);
    // start cycle: junk in_valid must be ignored while idle
    start = 1'b1; sub = s; in_valid = 1'b1; a_word = 16'hDEAD; b_word = 16'hBEEF;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random handshakes + spurious start,
  // 2: out_ready held low 3 cycles while word 2 is pending
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    int wi, ri, cyc, stall;
    logic acc, tk;
    model(s, a, b);
    do_start(s);
    wi = 0; ri = 0; cyc = 0; stall = 0;
    while (ri < N && cyc < 300) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          out_ready = !(out_valid && ri == 1 && stall < 3);
          if (!out_ready) stall++;
        end
      endcase
      in_valid = (wi < N) && (mode != 1 || $urandom_range(0, 3) != 0);
      a_word   = (wi < N) ? a[16*wi +: 16] : 16'($urandom);
      b_word   = (wi < N) ? b[16*wi +: 16] : 16'($urandom);
      start    = (mode == 1) && ($urandom_range(0, 4) == 0);
      sub      = 1'($urandom);
      #1;
      chk("busy", {31'd0, busy}, 32'd1);
      if (wi < N) chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      else        chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
      acc = in_valid && in_ready;
      tk  = out_valid && out_ready;
      if (tk) begin
        chk($sformatf("word%0d", ri), {16'd0, sum_word}, {16'd0, ref_r[16*ri +: 16]});
        chk($sformatf("last%0d", ri), {31'd0, last}, {31'd0, (ri == N - 1)});
        ri++;
      end
      if (acc) wi++;
      @(negedge clk);
      cyc++;
    end
    if (ri < N) chk("timeout", 32'(ri), 32'(N));
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("carry_out", {31'd0, carry_out}, {31'd0, ref_c});
`ifdef MULTIWORD_SIGNED_OVF_EN
    chk("overflow", {31'd0, overflow}, {31'd0, ref_v});
`endif
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sum"},  {16'd0, sum_word}, 32'd0);
    chk({tag, "_flags"}, {26'd0, out_valid, last, carry_out, busy, in_ready, 1'b0}, 32'd0);
`ifdef MULTIWORD_SIGNED_OVF_EN
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
`endif
  endtask

  initial begin
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors
    run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 0);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
    run_op(1'b1, 64'h5, 64'h7, 0);
    run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2);

    // reset in the middle of an operation, after two accepts
    do_start(1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a_word = 16'hFFFF; b_word = 16'hFFFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 64'h3, 64'h4, 0);

    // signed-overflow corners (carry/borrow checked in every build)
    run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0);
    run_op(1'b0, 64'h1, 64'h1, 0);
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'h1, 0);
    run_op(1'b1, 64'h7, 64'h7, 1);

    // randomized operations with random handshakes
    for (int t = 0; t < 20; t++)
      run_op(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL provide parameter NWORDS, default 4, meaning the number of 16-bit words per operand (2..16), least-significant word first.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL provide port start, input, 1, a one-cycle request to begin an operation; sampled only in IDLE.
REQ-005 SHALL provide port sub, input, 1, the operation select sampled with start: 0 = A+B, 1 = A-B.
REQ-006 SHALL provide ports in_valid, input, 1, and in_ready, output, 1, the operand-word handshake.
REQ-007 SHALL provide ports a_word and b_word, input, 16 each, the current operand words.
REQ-008 SHALL provide ports out_valid, input-side output, 1, and out_ready, input, 1, the result-word handshake.
REQ-009 SHALL provide port sum_word, output, 16, the registered result word.
REQ-010 SHALL provide port last, output, 1, high with the final result word of an operation.
REQ-011 SHALL provide ports carry_out, output, 1, the final carry (add) or not-borrow (sub); and busy, output, 1, high when not in IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-013 IDLE -> RUN on start: latch sub; load carry register = sub; clear word counter; other inputs ignored in IDLE.
REQ-014 In RUN, in_ready SHALL equal (!out_valid || out_ready); an accept is in_valid && in_ready.
REQ-015 Each accept SHALL register sum_word = a_word + (sub ? ~b_word : b_word) + carry (mod 2^16), update the carry register with bit 16, increment the counter and set out_valid the next cycle (latency 1).
REQ-016 last SHALL be registered high with the word produced from accept number NWORDS-1 (counter == NWORDS-1).
REQ-017 The accept of the final word SHALL move RUN -> DRAIN; in DRAIN, in_ready = 0.
REQ-018 DRAIN -> IDLE SHALL occur on the out_valid && out_ready && last handshake; carry_out updates at that edge and holds until the next final handshake.
REQ-019 When out_valid && !out_ready, sum_word, last and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-020 When a result is taken and a new word accepted in the same cycle, out_valid SHALL stay high with the new word; no bubble and no loss.
REQ-021 start while busy SHALL be ignored; in_valid in IDLE or DRAIN SHALL be ignored.
REQ-022 A combinational path out_ready -> in_ready is permitted; no other input-to-output combinational path SHALL exist.

Reset
REQ-023 On rst_n low, regardless of state, the block SHALL go immediately to IDLE and clear the counter, the carry register, out_valid, last, carry_out, sum_word (0x0000), busy and in_ready, plus overflow if present.
REQ-024 After rst_n deasserts, the first start SHALL begin a clean operation with no residue from an interrupted one.

Configuration
REQ-025 With macro MULTIWORD_SIGNED_OVF_EN defined, the block SHALL add output overflow, 1 bit (reset 0), set at the final handshake to the two's-complement overflow of the top word (carry into bit 15 XOR carry out of bit 15) and held like carry_out.
REQ-026 With MULTIWORD_SIGNED_OVF_EN undefined, the overflow port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 NWORDS=4, add, A=0x0000_0000_0000_FFFF, B=0x1 -> words 0x0000, 0x0001, 0x0000, 0x0000; last on word 4; carry_out=0.
REQ-028 Add, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> four words 0x0000; carry_out=1; FSM back in IDLE after the last handshake.
REQ-029 Sub, A=5, B=7 -> words 0xFFFE, 0xFFFF, 0xFFFF, 0xFFFF; carry_out=0 (borrow).
REQ-030 out_ready low for 3 cycles after word 2 -> sum_word stable, in_ready=0, all 4 words delivered in order with correct values.
REQ-031 rst_n pulsed low after 2 accepts -> all outputs 0 and busy=0 immediately; next start with A=3, B=4 gives word 0x0007, carry_out=0.
REQ-032 With MULTIWORD_SIGNED_OVF_EN: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> overflow=1 and carry_out=0; A=1, B=1 -> overflow=0.
